// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter with valid/ready handshakes.
// A W-bit word is accepted in IDLE, counted SLICE bits per clock in COUNT
// (ones, or zeros when mode=1), and the result is presented in DONE until
// the consumer takes it. Results can optionally be summed into a saturating
// running total.
//
// State table:
//   IDLE  | waiting for a word, in_ready=1
//   COUNT | summing one slice of the latched operand per clock
//   DONE  | count valid (out_valid=1), held until out_ready
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data/mode/acc_en valid
//   in_ready   out  block can accept a word
//   in_data    in   [W-1:0] word to count
//   mode       in   0 = count ones, 1 = count zeros
//   acc_en     in   add this word's result into acc
//   acc_clr    in   clear acc and acc_sat (any state)
//   out_valid  out  count valid
//   out_ready  in   consumer takes count
//   count      out  [NW-1:0] result for the last accepted word
//   acc        out  [AW-1:0] saturating running total
//   acc_sat    out  sticky saturation flag
module popcount_seq #(
    parameter int W     = 127,
    parameter int SLICE = 16,
    parameter int AW    = 16,
    localparam int NW   = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          mode,
    input  logic          acc_en,
    input  logic          acc_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] count,
    output logic [AW-1:0] acc,
    output logic          acc_sat
);

    localparam int NS = (W + SLICE - 1) / SLICE;
    localparam int PW = NS * SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   operand_q;
    logic            acc_en_q;
    logic [NW-1:0]   psum;
    logic [IW-1:0]   idx;

    logic [PW-1:0]   operand_d;
    logic [SLICE-1:0] slice_bits;
    logic [NW-1:0]   slice_cnt;
    logic [NW-1:0]   sum_next;
    logic            last;
    logic            upd;
    logic [AW-1:0]   acc_base;
    logic [AW-1:0]   acc_add;
    logic [AW:0]     acc_sum;

    always_comb begin
        // Padding above W stays zero in both modes, so it is never counted.
        operand_d        = '0;
        operand_d[W-1:0] = mode ? ~in_data : in_data;

        slice_bits = SLICE'(operand_q >> (int'(idx) * SLICE));
        slice_cnt  = '0;
        for (int i = 0; i < SLICE; i++) begin
            slice_cnt = slice_cnt + NW'(slice_bits[i]);
        end
        sum_next = psum + slice_cnt;
        last     = (idx == IW'(NS - 1));
        upd      = (state == COUNT) && last && acc_en_q;

        // Clear is applied before the add so a coinciding clear keeps the new count.
        acc_base = acc_clr ? '0 : acc;
        acc_add  = upd ? AW'(sum_next) : '0;
        acc_sum  = {1'b0, acc_base} + {1'b0, acc_add};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
            acc       <= '0;
            acc_sat   <= 1'b0;
            operand_q <= '0;
            acc_en_q  <= 1'b0;
            psum      <= '0;
            idx       <= '0;
        end else begin
            if (acc_clr || upd) begin
                acc     <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
                acc_sat <= (acc_clr ? 1'b0 : acc_sat) | acc_sum[AW];
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand_q <= operand_d;
                        acc_en_q  <= acc_en;
                        psum      <= '0;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    if (last) begin
                        count     <= sum_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        psum <= sum_next;
                        idx  <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq.sv
module tb_popcount_seq;

    localparam int W     = 127;
    localparam int SLICE = 16;
    localparam int AW    = 8;
    localparam int NW    = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          mode = 1'b0;
    logic          acc_en = 1'b0;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NW-1:0] count;
    logic [AW-1:0] acc;
    logic          acc_sat;

    int n_checks = 0;
    int n_pass   = 0;

    popcount_seq #(.W(W), .SLICE(SLICE), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a word for one accept edge, scramble the inputs afterwards,
    // then wait (bounded) for out_valid; lat = edges after accept.
    task automatic do_word(input logic [W-1:0] d, input logic m, input logic ae, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        acc_en   = ae;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        mode     = ~m;
        acc_en   = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (count !== NW'(0)) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (acc !== AW'(0)) $display("FAIL reset_acc: got %0d expected 0", acc); else n_pass++;
        n_checks++; if (acc_sat !== 1'b0) $display("FAIL reset_acc_sat: got %b expected 0", acc_sat); else n_pass++;
    endtask

    task automatic test_ones_latency();
        int lat;
        do_word('1, 1'b0, 1'b0, lat);
        n_checks++; if (lat != 8) $display("FAIL ones_latency: got %0d expected 8", lat); else n_pass++;
        n_checks++; if (count !== NW'(127)) $display("FAIL ones_count: got %0d expected 127", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL done_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (acc !== AW'(0)) $display("FAIL no_acc_en_acc: got %0d expected 0", acc); else n_pass++;
        release_out();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL after_release_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL after_release_out_valid: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_modes();
        int lat;
        logic [W-1:0] d;
        do_word('0, 1'b1, 1'b0, lat);
        n_checks++; if (count !== NW'(127)) $display("FAIL zeros_of_zero: got %0d expected 127", count); else n_pass++;
        release_out();
        d = '0; d[0] = 1'b1;
        do_word(d, 1'b1, 1'b0, lat);
        n_checks++; if (count !== NW'(126)) $display("FAIL zeros_of_one: got %0d expected 126", count); else n_pass++;
        release_out();
        do_word('1, 1'b1, 1'b0, lat);
        n_checks++; if (count !== NW'(0)) $display("FAIL zeros_of_ones: got %0d expected 0", count); else n_pass++;
        release_out();
        d = '0; d[W-1] = 1'b1;
        do_word(d, 1'b0, 1'b0, lat);
        n_checks++; if (count !== NW'(1)) $display("FAIL top_bit: got %0d expected 1", count); else n_pass++;
        n_checks++; if (lat != 8) $display("FAIL top_bit_latency: got %0d expected 8", lat); else n_pass++;
        release_out();
    endtask

    task automatic test_stall();
        int lat;
        int seen;
        logic [W-1:0] d;
        d = '0; d[11:0] = 12'hF0F;
        do_word(d, 1'b0, 1'b0, lat);
        n_checks++; if (count !== NW'(8)) $display("FAIL stall_count: got %0d expected 8", count); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            in_data  = {4{k[0], 31'h1234_5678}} ^ '1;
            @(posedge clk); #1;
            n_checks++;
            if (count !== NW'(8) || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL stall_hold: cycle %0d got count=%0d in_ready=%b out_valid=%b expected 8/0/1",
                         k, count, in_ready, out_valid);
            else n_pass++;
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen != 0) $display("FAIL stall_single_output: got %0d busy cycles expected 0", seen); else n_pass++;
    endtask

    task automatic test_accumulate();
        int lat;
        int exp_acc [3] = '{127, 254, 255};
        logic exp_sat [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_word('1, 1'b0, 1'b1, lat);
            n_checks++; if (acc !== AW'(exp_acc[i])) $display("FAIL acc_word%0d: got %0d expected %0d", i, acc, exp_acc[i]); else n_pass++;
            n_checks++; if (acc_sat !== exp_sat[i]) $display("FAIL acc_sat_word%0d: got %b expected %b", i, acc_sat, exp_sat[i]); else n_pass++;
            release_out();
        end
        repeat (2) @(posedge clk); #1;
        n_checks++; if (acc !== AW'(255) || acc_sat !== 1'b1) $display("FAIL acc_hold_idle: got %0d/%b expected 255/1", acc, acc_sat); else n_pass++;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        n_checks++; if (acc !== AW'(0)) $display("FAIL acc_clr_acc: got %0d expected 0", acc); else n_pass++;
        n_checks++; if (acc_sat !== 1'b0) $display("FAIL acc_clr_sat: got %b expected 0", acc_sat); else n_pass++;
    endtask

    task automatic test_clr_coincide();
        int lat;
        logic [W-1:0] d;
        do_word('1, 1'b0, 1'b1, lat);
        release_out();
        d = '0;
        for (int i = 0; i < 73; i++) d[i] = 1'b1;
        do_word(d, 1'b0, 1'b1, lat);
        n_checks++; if (count !== NW'(73)) $display("FAIL count_73: got %0d expected 73", count); else n_pass++;
        n_checks++; if (acc !== AW'(200)) $display("FAIL acc_200: got %0d expected 200", acc); else n_pass++;
        release_out();
        d = '0; d[4:0] = 5'h1F;
        in_valid = 1'b1; in_data = d; mode = 1'b0; acc_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_en = 1'b0; in_data = '1;
        repeat (7) @(posedge clk);
        #1 acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || count !== NW'(5)) $display("FAIL coincide_out: got valid=%b count=%0d expected 1/5", out_valid, count); else n_pass++;
        n_checks++; if (acc !== AW'(5)) $display("FAIL coincide_acc: got %0d expected 5", acc); else n_pass++;
        n_checks++; if (acc_sat !== 1'b0) $display("FAIL coincide_sat: got %b expected 0", acc_sat); else n_pass++;
        release_out();
    endtask

    task automatic test_midcount_reset();
        int lat;
        int seen;
        logic [127:0] t;
        in_valid = 1'b1; in_data = '1; mode = 1'b0; acc_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (count !== NW'(0)) $display("FAIL midreset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (acc !== AW'(0)) $display("FAIL midreset_acc: got %0d expected 0", acc); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", in_ready); else n_pass++;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || acc !== AW'(0)) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL midreset_abandon: got %0d stray cycles expected 0", seen); else n_pass++;
        t = {64{2'b01}};
        do_word(t[W-1:0], 1'b0, 1'b0, lat);
        n_checks++; if (count !== NW'(64)) $display("FAIL alt_pattern_count: got %0d expected 64", count); else n_pass++;
        n_checks++; if (lat != 8) $display("FAIL alt_pattern_latency: got %0d expected 8", lat); else n_pass++;
        release_out();
    endtask

    initial begin
        test_reset();
        test_ones_latency();
        test_modes();
        test_stall();
        test_accumulate();
        test_clr_coincide();
        test_midcount_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
